color_mapping_udiv_43ns_6ns_37_seq: RTL

- Sequential unsigned restoring divider; the inverse of the color_mapping 37x6 unsigned multiplier.
- Recovers a 37-bit operand from a 43-bit scaled product and a 6-bit factor, e.g. to normalise accumulated intensity back into the colour-index range before lookup.
- Produces one quotient bit per clock behind a valid/ready handshake.
- Sits in the color_mapping datapath between the accumulator and the palette LUT address stage.

---
 rtl/color_mapping_udiv_43ns_6ns_37_seq.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/color_mapping_udiv_43ns_6ns_37_seq.sv
// ---------------------------------------------------------------------------
// color_mapping_udiv_43ns_6ns_37_seq
//
// Sequential unsigned restoring divider for the color_mapping datapath. It
// recovers a 37-bit operand from a 43-bit scaled product and a 6-bit factor,
// producing one quotient bit per clock behind a valid/ready handshake.
//
// Ports:
//   ap_clk     in   clock, all state on the rising edge
//   ap_rst_n   in   asynchronous active-low reset
//   in_valid   in   operands valid
//   in_ready   out  divider can accept operands
//   din0       in   dividend (din0_WIDTH)
//   din1       in   divisor  (din1_WIDTH)
//   out_valid  out  result valid, held until out_ready
//   out_ready  in   consumer accepts result
//   dout       out  quotient (dout_WIDTH), saturated to all ones on ovf/dbz
//   rem        out  floor remainder (din1_WIDTH)
//   ovf        out  true quotient did not fit in dout_WIDTH bits
//   dbz        out  divide by zero
//
// Optional build macro:
//   COLOR_MAPPING_UDIV_ROUND_EN - round-half-up quotient (rem stays floor).
//   Undefined: truncating quotient.
//
// States:
//   state  | meaning
//   IDLE   | ready for operands
//   CALC   | one restoring step per cycle, din0_WIDTH cycles
//   DONE   | result presented until out_ready
// ---------------------------------------------------------------------------
module color_mapping_udiv_43ns_6ns_37_seq #(
    parameter int din0_WIDTH = 43,
    parameter int din1_WIDTH = 6,
    parameter int dout_WIDTH = 37
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  ovf,
    output logic                  dbz
);

    localparam int CNT_W = $clog2(din0_WIDTH);
    localparam int REM_W = din1_WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    // Goes high on the first clock after reset release; keeps in_ready low
    // while ap_rst_n is asserted.
    logic                    r_rst_sync;

    // Dividend shifts out MSB-first while quotient bits shift in at the LSB,
    // so after the last step this register holds the full quotient.
    logic [din0_WIDTH-1:0]   r_dividend;
    logic [din1_WIDTH-1:0]   r_divisor;
    logic [REM_W-1:0]        r_part;
    logic [CNT_W-1:0]        r_cnt;

    logic [dout_WIDTH-1:0]   r_dout;
    logic [din1_WIDTH-1:0]   r_rem;
    logic                    r_ovf;
    logic                    r_dbz;

    logic                    w_accept;
    logic                    w_last;
    logic [REM_W:0]          w_shift;
    logic [REM_W:0]          w_diff;
    logic                    w_qbit;
    logic [REM_W-1:0]        w_part_next;
    logic [din0_WIDTH-1:0]   w_quot_full;
    logic [din0_WIDTH:0]     w_quot_adj;
    logic                    w_ovf;
    logic [dout_WIDTH-1:0]   w_dout_sat;

    assign in_ready  = (r_state == S_IDLE) && r_rst_sync;
    assign out_valid = (r_state == S_DONE);
    assign dout      = r_dout;
    assign rem       = r_rem;
    assign ovf       = r_ovf;
    assign dbz       = r_dbz;

    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_state == S_CALC) && (r_cnt == '0);

    // Restoring step. The partial remainder is always < divisor, so after
    // shifting it fits in REM_W bits; one extra bit exposes the borrow.
    assign w_shift     = {r_part, r_dividend[din0_WIDTH-1]};
    assign w_diff      = w_shift - {2'b00, r_divisor};
    assign w_qbit      = ~w_diff[REM_W];
    assign w_part_next = w_qbit ? w_diff[REM_W-1:0] : w_shift[REM_W-1:0];
    assign w_quot_full = {r_dividend[din0_WIDTH-2:0], w_qbit};

`ifdef COLOR_MAPPING_UDIV_ROUND_EN
    // Round half up: bump the quotient when the remainder is at least half
    // the divisor. Done on the extended width so the increment feeds ovf.
    logic w_round;
    assign w_round    = ({w_part_next, 1'b0} >= {2'b00, r_divisor});
    assign w_quot_adj = {1'b0, w_quot_full} + {{din0_WIDTH{1'b0}}, w_round};
`else
    assign w_quot_adj = {1'b0, w_quot_full};
`endif

    assign w_ovf      = |w_quot_adj[din0_WIDTH:dout_WIDTH];
    assign w_dout_sat = w_ovf ? {dout_WIDTH{1'b1}} : w_quot_adj[dout_WIDTH-1:0];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = (din1 == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_rst_sync <= 1'b0;
        end else begin
            r_rst_sync <= 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_dividend <= '0;
            r_divisor  <= '0;
            r_part     <= '0;
            r_cnt      <= '0;
            r_dout     <= '0;
            r_rem      <= '0;
            r_ovf      <= 1'b0;
            r_dbz      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_dividend <= din0;
                        r_divisor  <= din1;
                        r_part     <= '0;
                        r_cnt      <= CNT_W'(din0_WIDTH - 1);
                        if (din1 == '0) begin
                            r_dout <= {dout_WIDTH{1'b1}};
                            r_rem  <= din0[din1_WIDTH-1:0];
                            r_ovf  <= 1'b0;
                            r_dbz  <= 1'b1;
                        end else begin
                            r_ovf  <= 1'b0;
                            r_dbz  <= 1'b0;
                        end
                    end
                end
                S_CALC: begin
                    r_dividend <= w_quot_full;
                    r_part     <= w_part_next;
                    if (w_last) begin
                        r_dout <= w_dout_sat;
                        r_rem  <= w_part_next[din1_WIDTH-1:0];
                        r_ovf  <= w_ovf;
                        r_dbz  <= 1'b0;
                    end else begin
                        r_cnt  <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
